// File: rtl/vga_timing_gen_pkg.sv
// VGA bus layout, default 1024x768@60 timing and test-pattern colour table shared
// by vga_timing_gen and everything downstream of it.
package vga_timing_gen_pkg;

    localparam int unsigned CNT_W       = 11;
    localparam int unsigned RGB_W       = 12;
    localparam int unsigned FRAME_CNT_W = 8;
    localparam int unsigned CNT_MAX     = (1 << CNT_W) - 1;

    // Bus field offsets, LSB first
    localparam int unsigned RGB_OFF      = 0;
    localparam int unsigned VCOUNT_OFF   = RGB_OFF + RGB_W;
    localparam int unsigned HCOUNT_OFF   = VCOUNT_OFF + CNT_W;
    localparam int unsigned VBLNK_OFF    = HCOUNT_OFF + CNT_W;
    localparam int unsigned HBLNK_OFF    = VBLNK_OFF + 1;
    localparam int unsigned VS_OFF       = HBLNK_OFF + 1;
    localparam int unsigned HS_OFF       = VS_OFF + 1;
    localparam int unsigned VGA_BUS_SIZE = HS_OFF + 1;

    localparam int unsigned H_ACTIVE_DEF = 1024;
    localparam int unsigned H_FP_DEF     = 24;
    localparam int unsigned H_SYNC_DEF   = 136;
    localparam int unsigned H_BP_DEF     = 160;
    localparam int unsigned V_ACTIVE_DEF = 768;
    localparam int unsigned V_FP_DEF     = 3;
    localparam int unsigned V_SYNC_DEF   = 6;
    localparam int unsigned V_BP_DEF     = 29;

    localparam logic [RGB_W-1:0] COL_WHITE   = 12'hFFF;
    localparam logic [RGB_W-1:0] COL_YELLOW  = 12'hFF0;
    localparam logic [RGB_W-1:0] COL_CYAN    = 12'h0FF;
    localparam logic [RGB_W-1:0] COL_GREEN   = 12'h0F0;
    localparam logic [RGB_W-1:0] COL_MAGENTA = 12'hF0F;
    localparam logic [RGB_W-1:0] COL_RED     = 12'hF00;
    localparam logic [RGB_W-1:0] COL_BLUE    = 12'h00F;
    localparam logic [RGB_W-1:0] COL_BLACK   = 12'h000;

    typedef struct packed {
        logic             hs;
        logic             vs;
        logic             hblnk;
        logic             vblnk;
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
        logic [RGB_W-1:0] rgb;
    } vga_bus_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } raster_state_t;

    // Bus value while held in reset or disabled: counters at origin, syncs inactive, blanked.
    function automatic vga_bus_t vga_bus_idle(input logic sync_pol);
        vga_bus_t b;
        b.hs     = ~sync_pol;
        b.vs     = ~sync_pol;
        b.hblnk  = 1'b1;
        b.vblnk  = 1'b1;
        b.hcount = '0;
        b.vcount = '0;
        b.rgb    = '0;
        return b;
    endfunction

    function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] idx);
        logic [RGB_W-1:0] c;
        case (idx)
            3'd0:    c = COL_WHITE;
            3'd1:    c = COL_YELLOW;
            3'd2:    c = COL_CYAN;
            3'd3:    c = COL_GREEN;
            3'd4:    c = COL_MAGENTA;
            3'd5:    c = COL_RED;
            3'd6:    c = COL_BLUE;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_counter.sv
// One raster axis: next count, wrap, and blank/sync decoded from the next count so the
// parent can register count and decodes together.
module vga_sync_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned TOTAL      = 1344,
    parameter int unsigned ACTIVE     = 1024,
    parameter int unsigned SYNC_START = 1048,
    parameter int unsigned SYNC_LEN   = 136,
    parameter logic        POL        = 1'b0
) (
    input  logic [CNT_W-1:0] count,
    input  logic             advance,
    output logic [CNT_W-1:0] count_nxt_c,
    output logic             blank_c,
    output logic             sync_c,
    output logic             wrap_c
);

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] BLANK_AT = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_LO  = CNT_W'(SYNC_START);
    localparam logic [CNT_W-1:0] SYNC_HI  = CNT_W'(SYNC_START + SYNC_LEN);

    always_comb begin
        wrap_c      = advance && (count == LAST);
        count_nxt_c = count;
        if (wrap_c) begin
            count_nxt_c = '0;
        end else if (advance) begin
            count_nxt_c = count + CNT_W'(1);
        end
        blank_c = (count_nxt_c >= BLANK_AT);
        sync_c  = ((count_nxt_c >= SYNC_LO) && (count_nxt_c < SYNC_HI)) ? POL : ~POL;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source for the VGA bus: counters, syncs, blanks, base rgb, frame strobe/count.
// Define VGA_TEST_PATTERN_EN to replace the background fill with 8 colour bars and a border.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned      H_ACTIVE         = H_ACTIVE_DEF,
    parameter int unsigned      H_FP             = H_FP_DEF,
    parameter int unsigned      H_SYNC           = H_SYNC_DEF,
    parameter int unsigned      H_BP             = H_BP_DEF,
    parameter int unsigned      V_ACTIVE         = V_ACTIVE_DEF,
    parameter int unsigned      V_FP             = V_FP_DEF,
    parameter int unsigned      V_SYNC           = V_SYNC_DEF,
    parameter int unsigned      V_BP             = V_BP_DEF,
    parameter logic             SYNC_POL         = 1'b0,
    parameter logic [RGB_W-1:0] BACKGROUND_COLOR = 12'h000
) (
    input  logic                   pclk,
    input  logic                   rst,
    input  logic                   enable,
    output vga_bus_t               vga_out,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if ((H_TOTAL > CNT_MAX) || (V_TOTAL > CNT_MAX)) begin : g_bad_timing
        $fatal(1, "vga_timing_gen: H_TOTAL=%0d / V_TOTAL=%0d exceed the 11-bit counters",
               H_TOTAL, V_TOTAL);
    end
    if ((H_ACTIVE == 0) || (V_ACTIVE == 0)) begin : g_bad_active
        $fatal(1, "vga_timing_gen: active area must be non-empty");
    end
    if ($bits(vga_bus_t) != VGA_BUS_SIZE) begin : g_bad_bus
        $fatal(1, "vga_timing_gen: bus struct does not match field offsets");
    end

    raster_state_t    state;
    logic [CNT_W-1:0] h_count_c;
    logic [CNT_W-1:0] v_count_c;
    logic             h_blank_c;
    logic             v_blank_c;
    logic             h_sync_c;
    logic             v_sync_c;
    logic             h_wrap_c;
    logic             v_wrap_c;
    logic             running_c;
    logic [RGB_W-1:0] rgb_nxt_c;
    vga_bus_t         bus_nxt_c;

    assign running_c = (state == ST_RUN);

    // While idle the bus already sits at 0/0, so holding advance low yields the 0/0 start.
    vga_sync_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_LEN   (H_SYNC),
        .POL        (SYNC_POL)
    ) u_hcnt (
        .count       (vga_out.hcount),
        .advance     (running_c),
        .count_nxt_c (h_count_c),
        .blank_c     (h_blank_c),
        .sync_c      (h_sync_c),
        .wrap_c      (h_wrap_c)
    );

    vga_sync_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_LEN   (V_SYNC),
        .POL        (SYNC_POL)
    ) u_vcnt (
        .count       (vga_out.vcount),
        .advance     (h_wrap_c),
        .count_nxt_c (v_count_c),
        .blank_c     (v_blank_c),
        .sync_c      (v_sync_c),
        .wrap_c      (v_wrap_c)
    );

    // Base colour for the pixel about to be registered.
    always_comb begin
        rgb_nxt_c = '0;
        if (!h_blank_c && !v_blank_c) begin
`ifdef VGA_TEST_PATTERN_EN
            if ((h_count_c == '0) || (h_count_c == CNT_W'(H_ACTIVE - 1)) ||
                (v_count_c == '0) || (v_count_c == CNT_W'(V_ACTIVE - 1))) begin
                rgb_nxt_c = COL_WHITE;
            end else begin
                rgb_nxt_c = bar_color(h_count_c[9:7]);
            end
`else
            rgb_nxt_c = BACKGROUND_COLOR;
`endif
        end
    end

    always_comb begin
        bus_nxt_c        = vga_bus_idle(SYNC_POL);
        bus_nxt_c.hs     = h_sync_c;
        bus_nxt_c.vs     = v_sync_c;
        bus_nxt_c.hblnk  = h_blank_c;
        bus_nxt_c.vblnk  = v_blank_c;
        bus_nxt_c.hcount = h_count_c;
        bus_nxt_c.vcount = v_count_c;
        bus_nxt_c.rgb    = rgb_nxt_c;
    end

    // The first frame after reset/resume strobes frame_start but leaves frame_cnt alone.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            vga_out     <= vga_bus_idle(SYNC_POL);
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else if (!enable) begin
            state       <= ST_IDLE;
            vga_out     <= vga_bus_idle(SYNC_POL);
            frame_start <= 1'b0;
        end else begin
            state       <= ST_RUN;
            vga_out     <= bus_nxt_c;
            frame_start <= !running_c || v_wrap_c;
            if (running_c && v_wrap_c) begin
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing line checks plus a shrunken raster for frame-level checks.
module tb_vga_timing_gen;
    import vga_timing_gen_pkg::*;

    localparam int unsigned D_HTOT  = 1344;
    localparam int unsigned SH_ACT  = 16;
    localparam int unsigned SV_ACT  = 8;
    localparam int unsigned SH_TOT  = 24;
    localparam int unsigned S_FRAME = 312;

    logic       pclk = 1'b0;
    logic       rst;
    logic       en_d;
    logic       en_s;
    vga_bus_t   bus_d;
    vga_bus_t   bus_s;
    logic       fs_d;
    logic       fs_s;
    logic [7:0] fc_d;
    logic [7:0] fc_s;

    int n_checks = 0;
    int n_fail   = 0;
    int pos_d    = 0;
    int pos_s    = 0;
    int period   = 0;

    always #5 pclk = ~pclk;

    vga_timing_gen #(
        .BACKGROUND_COLOR (12'hABC)
    ) u_dut_d (
        .pclk        (pclk),
        .rst         (rst),
        .enable      (en_d),
        .vga_out     (bus_d),
        .frame_start (fs_d),
        .frame_cnt   (fc_d)
    );

    vga_timing_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (2),
        .SYNC_POL (1'b0),
        .BACKGROUND_COLOR (12'hABC)
    ) u_dut_s (
        .pclk        (pclk),
        .rst         (rst),
        .enable      (en_s),
        .vga_out     (bus_s),
        .frame_start (fs_s),
        .frame_cnt   (fc_s)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_bus(input string tag, input vga_bus_t bus, input int h, input int v,
                             input logic hb, input logic vb, input logic hs, input logic vs,
                             input logic [11:0] rgb);
        check_eq({tag, ".hcount"}, 32'(bus.hcount), h);
        check_eq({tag, ".vcount"}, 32'(bus.vcount), v);
        check_eq({tag, ".hblnk"},  32'(bus.hblnk),  32'(hb));
        check_eq({tag, ".vblnk"},  32'(bus.vblnk),  32'(vb));
        check_eq({tag, ".hs"},     32'(bus.hs),     32'(hs));
        check_eq({tag, ".vs"},     32'(bus.vs),     32'(vs));
        check_eq({tag, ".rgb"},    32'(bus.rgb),    32'(rgb));
    endtask

    // Expected active-area colour for the build in use; 000 outside the active area.
    function automatic logic [11:0] act_rgb(input int h, input int v, input int h_act, input int v_act);
        if (h >= h_act || v >= v_act) return 12'h000;
`ifdef VGA_TEST_PATTERN_EN
        if (h == 0 || h == h_act - 1 || v == 0 || v == v_act - 1) return 12'hFFF;
        case ((h / 128) % 8)
            0: return 12'hFFF;
            1: return 12'hFF0;
            2: return 12'h0FF;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'hF00;
            6: return 12'h00F;
            default: return 12'h000;
        endcase
`else
        return 12'hABC;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic step_d(input int h, input int v);
        int tgt;
        tgt = v * D_HTOT + h;
        tick(tgt - pos_d);
        pos_d = tgt;
    endtask

    task automatic step_s(input int p);
        tick(p - pos_s);
        pos_s = p;
    endtask

    initial begin
        rst  = 1'b1;
        en_d = 1'b1;
        en_s = 1'b0;
        tick(3);
        check_bus("rst_d", bus_d, 0, 0, 1, 1, 1, 1, 12'h000);
        check_eq("rst_d.fs", 32'(fs_d), 0);
        check_eq("rst_d.fc", 32'(fc_d), 0);
        check_bus("rst_s", bus_s, 0, 0, 1, 1, 1, 1, 12'h000);

        // Default timing, one line and the start of the next
        rst = 1'b0;
        tick(1);
        pos_d = 0;
        check_bus("first_d", bus_d, 0, 0, 0, 0, 1, 1, act_rgb(0, 0, 1024, 768));
        check_eq("first_d.fs", 32'(fs_d), 1);
        check_eq("first_d.fc", 32'(fc_d), 0);
        step_d(1, 0);
        check_eq("d1.fs", 32'(fs_d), 0);
        check_eq("d1.hcount", 32'(bus_d.hcount), 1);
        step_d(1023, 0);
        check_bus("d1023", bus_d, 1023, 0, 0, 0, 1, 1, act_rgb(1023, 0, 1024, 768));
        step_d(1024, 0);
        check_bus("d1024", bus_d, 1024, 0, 1, 0, 1, 1, 12'h000);
        step_d(1047, 0);
        check_eq("d1047.hs", 32'(bus_d.hs), 1);
        step_d(1048, 0);
        check_eq("d1048.hs", 32'(bus_d.hs), 0);
        step_d(1183, 0);
        check_eq("d1183.hs", 32'(bus_d.hs), 0);
        step_d(1184, 0);
        check_eq("d1184.hs", 32'(bus_d.hs), 1);
        step_d(1343, 0);
        check_bus("d1343", bus_d, 1343, 0, 1, 0, 1, 1, 12'h000);
        step_d(0, 1);
        check_bus("d_line1", bus_d, 0, 1, 0, 0, 1, 1, act_rgb(0, 1, 1024, 768));
        check_eq("d_line1.fs", 32'(fs_d), 0);
        step_d(200, 1);
        check_eq("d200_1.rgb", 32'(bus_d.rgb), 32'(act_rgb(200, 1, 1024, 768)));
        step_d(1000, 1);
        check_eq("d1000_1.rgb", 32'(bus_d.rgb), 32'(act_rgb(1000, 1, 1024, 768)));
        step_d(1023, 1);
        check_eq("d1023_1.rgb", 32'(bus_d.rgb), 32'(act_rgb(1023, 1, 1024, 768)));

        // Hand over to the small raster; the default instance must fall back to idle
        en_d = 1'b0;
        en_s = 1'b1;
        tick(1);
        pos_s = 0;
        check_bus("d_off", bus_d, 0, 0, 1, 1, 1, 1, 12'h000);
        check_eq("d_off.fc", 32'(fc_d), 0);
        check_bus("s_first", bus_s, 0, 0, 0, 0, 1, 1, act_rgb(0, 0, SH_ACT, SV_ACT));
        check_eq("s_first.fs", 32'(fs_s), 1);
        check_eq("s_first.fc", 32'(fc_s), 0);

        step_s(7 * SH_TOT + 15);
        check_bus("s15_7", bus_s, 15, 7, 0, 0, 1, 1, act_rgb(15, 7, SH_ACT, SV_ACT));
        step_s(7 * SH_TOT + 16);
        check_bus("s16_7", bus_s, 16, 7, 1, 0, 1, 1, 12'h000);
        step_s(7 * SH_TOT + 18);
        check_eq("s18_7.hs", 32'(bus_s.hs), 0);
        step_s(7 * SH_TOT + 20);
        check_eq("s20_7.hs", 32'(bus_s.hs), 0);
        step_s(7 * SH_TOT + 21);
        check_eq("s21_7.hs", 32'(bus_s.hs), 1);
        step_s(8 * SH_TOT);
        check_bus("s0_8", bus_s, 0, 8, 0, 1, 1, 1, 12'h000);
        step_s(9 * SH_TOT);
        check_eq("s0_9.vs", 32'(bus_s.vs), 0);
        step_s(10 * SH_TOT + 23);
        check_bus("s23_10", bus_s, 23, 10, 1, 1, 1, 0, 12'h000);
        step_s(11 * SH_TOT);
        check_eq("s0_11.vs", 32'(bus_s.vs), 1);
        step_s(12 * SH_TOT + 23);
        check_bus("s23_12", bus_s, 23, 12, 1, 1, 1, 1, 12'h000);
        check_eq("s23_12.fs", 32'(fs_s), 0);
        check_eq("s23_12.fc", 32'(fc_s), 0);
        step_s(S_FRAME);
        check_bus("s_frame1", bus_s, 0, 0, 0, 0, 1, 1, act_rgb(0, 0, SH_ACT, SV_ACT));
        check_eq("s_frame1.fs", 32'(fs_s), 1);
        check_eq("s_frame1.fc", 32'(fc_s), 1);
        step_s(S_FRAME + 1);
        check_eq("s_frame1p1.fs", 32'(fs_s), 0);

        // Frame period measured between strobes, bounded
        period = 1;
        while (fs_s !== 1'b1 && period < 1000) begin
            tick(1);
            period++;
        end
        pos_s = S_FRAME + period;
        check_eq("frame_period", period, S_FRAME);
        check_eq("s_frame2.fc", 32'(fc_s), 2);

        // Drop enable mid-frame at (5,4)
        step_s(2 * S_FRAME + 4 * SH_TOT + 5);
        check_eq("s5_4.hcount", 32'(bus_s.hcount), 5);
        en_s = 1'b0;
        tick(1);
        check_bus("s_dis", bus_s, 0, 0, 1, 1, 1, 1, 12'h000);
        check_eq("s_dis.fs", 32'(fs_s), 0);
        check_eq("s_dis.fc", 32'(fc_s), 2);
        tick(3);
        check_eq("s_dis_hold.hcount", 32'(bus_s.hcount), 0);
        check_eq("s_dis_hold.fc", 32'(fc_s), 2);
        en_s = 1'b1;
        tick(1);
        pos_s = 0;
        check_bus("s_resume", bus_s, 0, 0, 0, 0, 1, 1, act_rgb(0, 0, SH_ACT, SV_ACT));
        check_eq("s_resume.fs", 32'(fs_s), 1);
        check_eq("s_resume.fc", 32'(fc_s), 2);
        step_s(S_FRAME);
        check_eq("s_resume_f1.fs", 32'(fs_s), 1);
        check_eq("s_resume_f1.fc", 32'(fc_s), 3);

        // Asynchronous reset between clock edges at (7,2)
        step_s(S_FRAME + 2 * SH_TOT + 7);
        check_eq("s7_2.hcount", 32'(bus_s.hcount), 7);
        #3;
        rst = 1'b1;
        #1;
        check_bus("s_arst", bus_s, 0, 0, 1, 1, 1, 1, 12'h000);
        check_eq("s_arst.fs", 32'(fs_s), 0);
        check_eq("s_arst.fc", 32'(fc_s), 0);
        tick(2);
        check_eq("s_arst_hold.hcount", 32'(bus_s.hcount), 0);
        rst = 1'b0;
        tick(1);
        pos_s = 0;
        check_bus("s_rst_rel", bus_s, 0, 0, 0, 0, 1, 1, act_rgb(0, 0, SH_ACT, SV_ACT));
        check_eq("s_rst_rel.fs", 32'(fs_s), 1);
        check_eq("s_rst_rel.fc", 32'(fc_s), 0);
        step_s(S_FRAME);
        check_eq("s_rst_f1.fs", 32'(fs_s), 1);
        check_eq("s_rst_f1.fc", 32'(fc_s), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
